uart_byte_rx: RTL

//  UART byte receiver, 8N1, LSB first; complement of the existing UART byte transmitter.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_tick_gen.sv | 67 ++++++
 rtl/uart_byte_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, oversampling
// constants, baud rates and the divider arithmetic used by the tick generator.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_OVS = 16;

    // Oversample ticks at which the three majority-vote samples are taken
    localparam logic [3:0] TICK_S0 = 4'd7;
    localparam logic [3:0] TICK_S1 = 4'd8;
    localparam logic [3:0] TICK_S2 = 4'd9;

    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_38400  = 38400;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    // Clocks per oversample tick, truncated; only ever evaluated on constants
    function automatic logic [15:0] div_value(input int clk_freq, input int rate);
        return 16'(clk_freq / (rate * UART_OVS));
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: latches the rate select on a frame start, restarts
// its down-counter there and emits a one-clock tick every DIV clocks.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] baud_set,
    output logic       tick
);

    localparam logic [15:0] RELOAD_0 = div_value(CLK_FREQ, BAUD_9600)   - 16'd1;
    localparam logic [15:0] RELOAD_1 = div_value(CLK_FREQ, BAUD_19200)  - 16'd1;
    localparam logic [15:0] RELOAD_2 = div_value(CLK_FREQ, BAUD_38400)  - 16'd1;
    localparam logic [15:0] RELOAD_3 = div_value(CLK_FREQ, BAUD_57600)  - 16'd1;
    localparam logic [15:0] RELOAD_4 = div_value(CLK_FREQ, BAUD_115200) - 16'd1;

    // Unlisted select codes fall back to the slowest rate
    function automatic logic [15:0] reload_for(input logic [3:0] sel);
        case (sel)
            4'd1:    return RELOAD_1;
            4'd2:    return RELOAD_2;
            4'd3:    return RELOAD_3;
            4'd4:    return RELOAD_4;
            default: return RELOAD_0;
        endcase
    endfunction

    logic [3:0]  baud_q, baud_d;
    logic [15:0] cnt_q,  cnt_d;
    logic        tick_q, tick_d;

    // Next-state: reload from the new select on clear, else count down to zero
    always_comb begin
        baud_d = baud_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            baud_d = baud_set;
            cnt_d  = reload_for(baud_set);
        end else if (cnt_q == 16'd0) begin
            cnt_d  = reload_for(baud_q);
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q - 16'd1;
        end
    end

    // Divider registers
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            baud_q <= 4'd0;
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with 16x oversampling and 3-sample majority vote.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | waiting for a falling edge on the synchronised line
//  ST_START | confirming the start bit; a high vote at mid-bit is a glitch
//  ST_DATA  | shifting in 8 data bits, LSB first
//  ST_STOP  | checking the stop bit; high -> rx_done, low -> frame_err
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OVS      = 16
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [3:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       hist_q,  hist_d;
    logic [1:0] warm_q,  warm_d;
    logic       armed_q, armed_d;

    uart_state_t state_q, state_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        samp0_q, samp0_d;
    logic        samp1_q, samp1_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;
    logic        uart_state_q, uart_state_d;

    logic start_edge;
    logic tick;
    logic vote;

    // Synchroniser path; the edge detector is armed only once a real high
    // sample has come through, so a line held low over reset cannot start a frame
    always_comb begin
        sync1_d = rs232_rx;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        warm_d  = {warm_q[0], 1'b1};
        armed_d = armed_q | (warm_q[1] & sync2_q);
    end

    // Synchroniser registers
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

    assign start_edge = armed_q & hist_q & ~sync2_q & (state_q == ST_IDLE);
    assign vote = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);

    uart_rx_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .mclk     (mclk),
        .rst      (rst),
        .clear    (start_edge),
        .baud_set (baud_set),
        .tick     (tick)
    );

    // Frame FSM next-state: vote at the third sample tick, advance at the last tick
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
        shift_d      = shift_q;
        data_byte_d  = data_byte_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
        uart_state_d = uart_state_q;

        if (state_q == ST_IDLE) begin
            if (start_edge) begin
                state_d      = ST_START;
                tick_cnt_d   = 4'd0;
                uart_state_d = 1'b1;
            end
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == LAST_TICK) ? 4'd0 : tick_cnt_q + 4'd1;
            if (tick_cnt_q == TICK_S0) samp0_d = sync2_q;
            if (tick_cnt_q == TICK_S1) samp1_d = sync2_q;

            case (state_q)
                ST_START: begin
                    if (tick_cnt_q == TICK_S2 && vote) begin
                        state_d      = ST_IDLE;
                        uart_state_d = 1'b0;
                    end else if (tick_cnt_q == LAST_TICK) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_S2) shift_d = {vote, shift_q[7:1]};
                    if (tick_cnt_q == LAST_TICK) begin
                        if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                        else                   bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start
                    if (tick_cnt_q == TICK_S2) begin
                        if (vote) begin
                            data_byte_d = shift_q;
                            rx_done_d   = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d      = ST_IDLE;
                        uart_state_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    uart_state_d = 1'b0;
                end
            endcase
        end
    end

    // Frame FSM and registered outputs
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            shift_q      <= 8'h00;
            data_byte_q  <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            uart_state_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            uart_state_q <= uart_state_d;
        end
    end

    assign data_byte  = data_byte_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign uart_state = uart_state_q;

endmodule
